// File: rtl/meikyuu_defs_pkg.sv
// Shared definitions for the meikyuu input path: direction codes, movement FSM
// states and the default button timing constants.
package meikyuu_defs;

    localparam logic [1:0] DIR_UP    = 2'b00;
    localparam logic [1:0] DIR_DOWN  = 2'b01;
    localparam logic [1:0] DIR_LEFT  = 2'b10;
    localparam logic [1:0] DIR_RIGHT = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_DELAY  = 2'b01,
        ST_REPEAT = 2'b10
    } move_state_t;

    localparam int DEF_DEBOUNCE_CYC     = 500_000;
    localparam int DEF_REPEAT_DELAY_CYC = 12_500_000;
    localparam int DEF_REPEAT_PER_CYC   = 833_333;
    localparam int DEF_CNT_W            = 24;

    function automatic longint max3(input longint a, input longint b, input longint c);
        longint m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// One button: 2-FF synchroniser, polarity normalisation (1 = pressed) and a
// counter-based debouncer that only moves after DEBOUNCE_CYC stable cycles.
module btn_debounce #(
    parameter int DEBOUNCE_CYC   = 500_000,
    parameter bit BTN_ACTIVE_LOW = 1'b1,
    parameter int CNT_W          = 24
) (
    input  logic CLOCK_50,
    input  logic reset,
    input  logic raw,
    output logic level
);

    localparam logic IDLE_LVL = BTN_ACTIVE_LOW ? 1'b1 : 1'b0;

    logic             sync1;
    logic             sync2;
    logic             pressed;
    logic [CNT_W-1:0] cnt;

    // Sync flops reset to the released electrical level so reset reads as not-pressed.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            sync1 <= IDLE_LVL;
            sync2 <= IDLE_LVL;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    assign pressed = sync2 ^ IDLE_LVL;

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            level <= 1'b0;
            cnt   <= '0;
        end else if (pressed != level) begin
            if (cnt == CNT_W'(DEBOUNCE_CYC - 1)) begin
                level <= pressed;
                cnt   <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end else begin
            cnt <= '0;
        end
    end

endmodule

// File: rtl/btn_move_ctrl.sv
// Turns four raw direction buttons into rate-limited step commands (first step
// at once, then auto-repeat) delivered over a single-entry valid/ready handshake.
module btn_move_ctrl
    import meikyuu_defs::*;
#(
    parameter bit BTN_ACTIVE_LOW   = 1'b1,
    parameter int DEBOUNCE_CYC     = DEF_DEBOUNCE_CYC,
    parameter int REPEAT_DELAY_CYC = DEF_REPEAT_DELAY_CYC,
    parameter int REPEAT_PER_CYC   = DEF_REPEAT_PER_CYC,
    parameter int CNT_W            = DEF_CNT_W
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       btn_up_raw,
    input  logic       btn_down_raw,
    input  logic       btn_left_raw,
    input  logic       btn_right_raw,
    input  logic       step_ready,
    output logic       step_valid,
    output logic [1:0] step_dir,
    output logic [3:0] held,
    output logic       overrun
);

    localparam longint MAX_CYC = max3(longint'(DEBOUNCE_CYC), longint'(REPEAT_DELAY_CYC),
                                      longint'(REPEAT_PER_CYC));
    localparam logic [CNT_W-1:0] DELAY_LOAD = CNT_W'(REPEAT_DELAY_CYC - 1);
    localparam logic [CNT_W-1:0] PER_LOAD   = CNT_W'(REPEAT_PER_CYC - 1);

    if (MAX_CYC >= (longint'(1) << CNT_W)) begin : g_cnt_w_check
        $error("btn_move_ctrl: CNT_W too narrow for the configured cycle counts");
    end

    logic [3:0]       raw_vec;
    logic             req_any;
    logic [1:0]       req_dir;
    logic             issue;
    logic [1:0]       last_dir;
    logic [CNT_W-1:0] rcnt;
    move_state_t      state;

    assign raw_vec = {btn_right_raw, btn_left_raw, btn_down_raw, btn_up_raw};

    for (genvar i = 0; i < 4; i++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYC  (DEBOUNCE_CYC),
            .BTN_ACTIVE_LOW(BTN_ACTIVE_LOW),
            .CNT_W         (CNT_W)
        ) u_btn (
            .CLOCK_50(CLOCK_50),
            .reset   (reset),
            .raw     (raw_vec[i]),
            .level   (held[i])
        );
    end

    // Opposing pairs cancel each other; what is left resolves up > down > left > right.
    always_comb begin
        req_any = 1'b1;
        req_dir = DIR_UP;
        if (held[0] && !held[1])      req_dir = DIR_UP;
        else if (held[1] && !held[0]) req_dir = DIR_DOWN;
        else if (held[2] && !held[3]) req_dir = DIR_LEFT;
        else if (held[3] && !held[2]) req_dir = DIR_RIGHT;
        else                          req_any = 1'b0;
    end

    always_comb begin
        issue = 1'b0;
        if (req_any) begin
            if (state == ST_IDLE)                         issue = 1'b1;
            else if (req_dir != last_dir || rcnt == '0)   issue = 1'b1;
        end
    end

    // A step that cannot be handed over is dropped and flagged; the pending one stays intact.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            rcnt       <= '0;
            last_dir   <= DIR_UP;
            step_valid <= 1'b0;
            step_dir   <= DIR_UP;
            overrun    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_any) begin
                        state    <= ST_DELAY;
                        rcnt     <= DELAY_LOAD;
                        last_dir <= req_dir;
                    end
                end
                default: begin
                    if (!req_any) begin
                        state <= ST_IDLE;
                    end else if (req_dir != last_dir) begin
                        state    <= ST_DELAY;
                        rcnt     <= DELAY_LOAD;
                        last_dir <= req_dir;
                    end else if (rcnt == '0) begin
                        state <= ST_REPEAT;
                        rcnt  <= PER_LOAD;
                    end else begin
                        rcnt <= rcnt - CNT_W'(1);
                    end
                end
            endcase

            if (issue && (!step_valid || step_ready)) begin
                step_valid <= 1'b1;
                step_dir   <= req_dir;
            end else begin
                if (issue)      overrun    <= 1'b1;
                if (step_ready) step_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_btn_move_ctrl.sv
// Directed bench for btn_move_ctrl with short timing parameters; transfers are
// logged at the clock edge and compared against hand-computed cycle numbers.
module tb_btn_move_ctrl;
    import meikyuu_defs::*;

    logic       clk        = 1'b0;
    logic       reset      = 1'b1;
    logic       up_raw     = 1'b1;
    logic       down_raw   = 1'b1;
    logic       left_raw   = 1'b1;
    logic       right_raw  = 1'b1;
    logic       step_ready = 1'b1;
    logic       step_valid;
    logic [1:0] step_dir;
    logic [3:0] held;
    logic       overrun;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int base;

    typedef struct {
        int         cyc;
        logic [1:0] dir;
    } xfer_t;

    xfer_t      xq[$];
    xfer_t      mon_x;
    int         exp_cyc[$];
    logic [1:0] exp_dir[$];

    btn_move_ctrl #(
        .BTN_ACTIVE_LOW  (1'b1),
        .DEBOUNCE_CYC    (4),
        .REPEAT_DELAY_CYC(20),
        .REPEAT_PER_CYC  (5),
        .CNT_W           (24)
    ) dut (
        .CLOCK_50     (clk),
        .reset        (reset),
        .btn_up_raw   (up_raw),
        .btn_down_raw (down_raw),
        .btn_left_raw (left_raw),
        .btn_right_raw(right_raw),
        .step_ready   (step_ready),
        .step_valid   (step_valid),
        .step_dir     (step_dir),
        .held         (held),
        .overrun      (overrun)
    );

    always #10 clk = ~clk;

    // cyc is the index of the edge at which a transfer is recorded
    always @(posedge clk) begin
        if (step_valid && step_ready) begin
            mon_x.cyc = cyc;
            mon_x.dir = step_dir;
            xq.push_back(mon_x);
        end
        cyc <= cyc + 1;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_xfers(input string tag);
        check($sformatf("%s_count", tag), xq.size(), exp_cyc.size());
        foreach (exp_cyc[i]) begin
            if (i < xq.size()) begin
                check($sformatf("%s_cyc%0d", tag, i), xq[i].cyc, exp_cyc[i]);
                check($sformatf("%s_dir%0d", tag, i), 32'(xq[i].dir), 32'(exp_dir[i]));
            end
        end
    endtask

    task automatic release_all();
        up_raw = 1'b1; down_raw = 1'b1; left_raw = 1'b1; right_raw = 1'b1;
    endtask

    initial begin
        // 1: reset held while buttons bounce
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            up_raw    = 1'($urandom_range(0, 1));
            down_raw  = 1'($urandom_range(0, 1));
            left_raw  = 1'($urandom_range(0, 1));
            right_raw = 1'($urandom_range(0, 1));
            check("rst_held", held, 0);
            check("rst_valid", step_valid, 0);
        end
        release_all();
        reset = 1'b0;
        tick(10);
        check("post_rst_held", held, 0);
        check("post_rst_valid", step_valid, 0);
        check("post_rst_dir", step_dir, 0);
        check("post_rst_overrun", overrun, 0);

        // 2: up with 3-cycle glitches, then stable
        for (int g = 0; g < 2; g++) begin
            up_raw = 1'b0; tick(3);
            up_raw = 1'b1; tick(3);
        end
        check("glitch_rejected", held, 0);
        up_raw = 1'b0;
        tick(5);
        check("up_held_lat5", held[0], 0);
        tick(1);
        check("up_held_lat6", held[0], 1);
        check("up_valid_lat6", step_valid, 0);
        tick(1);
        check("up_valid_lat7", step_valid, 1);
        check("up_dir", step_dir, DIR_UP);
        tick(1);
        check("up_valid_drop", step_valid, 0);
        release_all();
        tick(20);

        // 3: right held, immediate step then delay and repeat
        xq.delete();
        base = cyc;
        right_raw = 1'b0;
        tick(64);
        release_all();
        tick(15);
        exp_cyc = {base + 7};
        for (int k = 0; k < 9; k++) exp_cyc.push_back(base + 27 + 5 * k);
        exp_dir = {};
        for (int k = 0; k < 10; k++) exp_dir.push_back(DIR_RIGHT);
        check_xfers("right_rep");
        check("right_idle_valid", step_valid, 0);

        // 4a: up+left resolves to up
        xq.delete();
        base = cyc;
        up_raw = 1'b0; left_raw = 1'b0;
        tick(28);
        release_all();
        tick(15);
        exp_cyc = {base + 7, base + 27, base + 32};
        exp_dir = {DIR_UP, DIR_UP, DIR_UP};
        check_xfers("up_left");

        // 4b: up+down+left resolves to left
        xq.delete();
        base = cyc;
        up_raw = 1'b0; down_raw = 1'b0; left_raw = 1'b0;
        tick(28);
        release_all();
        tick(15);
        exp_cyc = {base + 7, base + 27, base + 32};
        exp_dir = {DIR_LEFT, DIR_LEFT, DIR_LEFT};
        check_xfers("up_down_left");

        // 4c: up+down cancels completely
        xq.delete();
        up_raw = 1'b0; down_raw = 1'b0;
        tick(28);
        check("up_down_held", held, 4'b0011);
        check("up_down_valid", step_valid, 0);
        release_all();
        tick(15);
        check("up_down_none", xq.size(), 0);

        // 5: consumer stalled, repeat overruns
        xq.delete();
        step_ready = 1'b0;
        left_raw = 1'b0;
        tick(7);
        check("stall_valid", step_valid, 1);
        check("stall_dir", step_dir, DIR_LEFT);
        check("stall_ovr0", overrun, 0);
        tick(19);
        check("stall_ovr_pre", overrun, 0);
        tick(1);
        check("stall_ovr_set", overrun, 1);
        check("stall_valid2", step_valid, 1);
        check("stall_dir2", step_dir, DIR_LEFT);
        tick(13);
        release_all();
        tick(15);
        check("stall_kept_valid", step_valid, 1);
        check("stall_kept_dir", step_dir, DIR_LEFT);
        check("stall_no_xfer", xq.size(), 0);
        step_ready = 1'b1;
        tick(1);
        check("stall_drained", step_valid, 0);
        tick(3);
        check("stall_one_xfer", xq.size(), 1);
        if (xq.size() > 0) check("stall_xfer_dir", xq[0].dir, DIR_LEFT);
        check("stall_ovr_sticky", overrun, 1);

        // reset mid-operation with left still pressed
        reset = 1'b1;
        left_raw = 1'b0;
        tick(2);
        check("midrst_valid", step_valid, 0);
        check("midrst_ovr", overrun, 0);
        check("midrst_held", held, 0);
        reset = 1'b0;
        tick(6);
        check("midrst_held_back", held[2], 1);
        check("midrst_no_step", step_valid, 0);
        tick(1);
        check("midrst_fresh_step", step_valid, 1);
        check("midrst_fresh_dir", step_dir, DIR_LEFT);
        release_all();
        tick(20);

        // 6: down -> left mid-delay restarts the repeat timer
        xq.delete();
        base = cyc;
        down_raw = 1'b0;
        tick(10);
        down_raw = 1'b1; left_raw = 1'b0;
        tick(35);
        release_all();
        tick(15);
        exp_cyc = {base + 7, base + 17, base + 37, base + 42, base + 47};
        exp_dir = {DIR_DOWN, DIR_LEFT, DIR_LEFT, DIR_LEFT, DIR_LEFT};
        check_xfers("dir_change");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
